// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU-side control/loader and the main-memory responder.
interface mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        CPUstate;
  logic [ADDR_W-1:0] addr;
  logic              mem_read;
  logic              mem_write;
  logic              mem2bus;
  logic              bus2mem;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              chk_req;
  logic              chk_valid;
  logic [DATA_W-1:0] chk_data;
  logic              chk_done;
  logic [MEM_AW:0]   load_len;
  logic              err;

  modport slave (
    input  CPUstate, addr, mem_read, mem_write, mem2bus, bus2mem, bus_in,
           ld_valid, ld_data, chk_req,
    output bus_out, bus_oe, ld_ready, chk_valid, chk_data, chk_done, load_len, err
  );

  modport master (
    output CPUstate, addr, mem_read, mem_write, mem2bus, bus2mem, bus_in,
           ld_valid, ld_data, chk_req,
    input  bus_out, bus_oe, ld_ready, chk_valid, chk_data, chk_done, load_len, err
  );
endinterface

// File: rtl/mem_responder.sv
// Main-memory responder: CPU read/write port, program loader and readback path.
// Optional build macro MEM_WP_EN write-protects the loaded image while running.
module mem_responder #(
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 8,
  parameter int DATA_W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mem_responder_if.slave bus
);
  // state   | meaning
  // S_IDLE  | nothing owns the RAM; any CPU strobe is an error
  // S_LOAD  | loader streams bytes into RAM from address 0
  // S_CHECK | loaded bytes are read back in order
  // S_RUN   | CPU owns the RAM through the bus strobes
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_CHECK = 2'b10,
    S_RUN   = 2'b11
  } state_e;

  localparam int              DEPTH   = 1 << MEM_AW;
  localparam logic [MEM_AW:0] LEN_ONE = {{MEM_AW{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [MEM_AW:0]   ptr_q, ptr_d;
  logic [MEM_AW:0]   load_len_q, load_len_d;
  logic              err_q, err_d;
  logic              chk_valid_q, chk_valid_d;
  logic              chk_done_q, chk_done_d;
  logic [DATA_W-1:0] chk_data_q, chk_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ram_we;
  logic [MEM_AW-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic [MEM_AW-1:0] cpu_a;
  logic              in_run, ld_rdy, ld_fire, chk_fire, cpu_wr, cpu_any, wp_hit;
  logic              unused_addr;

  assign cpu_a       = bus.addr[MEM_AW-1:0];
  assign unused_addr = ^bus.addr[ADDR_W-1:MEM_AW];

  assign in_run   = (state_q == S_RUN);
  assign ld_rdy   = (state_q == S_LOAD) && !load_len_q[MEM_AW];
  assign ld_fire  = bus.ld_valid && ld_rdy;
  assign chk_fire = (state_q == S_CHECK) && bus.chk_req && (ptr_q < load_len_q);
  assign cpu_wr   = bus.mem_write && bus.bus2mem && !bus.mem_read;
  assign cpu_any  = bus.mem_read || bus.mem_write || bus.mem2bus || bus.bus2mem;

`ifdef MEM_WP_EN
  assign wp_hit = ({1'b0, cpu_a} < load_len_q);
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_len_d  = load_len_q;
    err_d       = err_q;
    chk_valid_d = 1'b0;
    chk_data_d  = chk_data_q;
    chk_done_d  = chk_done_q;
    ram_we      = 1'b0;
    ram_wa      = ptr_q[MEM_AW-1:0];
    ram_wd      = bus.ld_data;

    case (bus.CPUstate)
      2'b00:   state_d = S_IDLE;
      2'b01:   state_d = S_LOAD;
      2'b10:   state_d = S_CHECK;
      default: state_d = S_RUN;
    endcase

    if (ld_fire) begin
      ram_we     = 1'b1;
      ptr_d      = ptr_q + LEN_ONE;
      load_len_d = load_len_q + LEN_ONE;
    end
    if ((state_q == S_LOAD) && bus.ld_valid && load_len_q[MEM_AW]) err_d = 1'b1;

    if (chk_fire) begin
      chk_valid_d = 1'b1;
      chk_data_d  = mem_q[ptr_q[MEM_AW-1:0]];
      ptr_d       = ptr_q + LEN_ONE;
      if ((ptr_q + LEN_ONE) == load_len_q) chk_done_d = 1'b1;
    end

    if (in_run) begin
      if (cpu_wr && !wp_hit) begin
        ram_we = 1'b1;
        ram_wa = cpu_a;
        ram_wd = bus.bus_in;
      end
      if ((bus.mem_write && !bus.bus2mem) || (bus.mem_read && bus.mem_write) ||
          (cpu_wr && wp_hit)) err_d = 1'b1;
    end else if (cpu_any) begin
      err_d = 1'b1;
    end

    // State entry overrides any same-edge pointer update from the old state
    if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
      ptr_d      = '0;
      load_len_d = '0;
    end
    if ((state_d == S_CHECK) && (state_q != S_CHECK)) begin
      ptr_d      = '0;
      chk_done_d = (load_len_q == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      load_len_q  <= '0;
      err_q       <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_data_q  <= '0;
      chk_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_len_q  <= load_len_d;
      err_q       <= err_d;
      chk_valid_q <= chk_valid_d;
      chk_data_q  <= chk_data_d;
      chk_done_q  <= chk_done_d;
    end
  end

  // RAM survives reset
  always_ff @(posedge clk_i) begin
    if (ram_we) mem_q[ram_wa] <= ram_wd;
  end

  assign bus.bus_oe    = bus.mem_read && bus.mem2bus && in_run;
  assign bus.bus_out   = bus.bus_oe ? mem_q[cpu_a] : '0;
  assign bus.ld_ready  = ld_rdy;
  assign bus.chk_valid = chk_valid_q;
  assign bus.chk_data  = chk_data_q;
  assign bus.chk_done  = chk_done_q;
  assign bus.load_len  = load_len_q;
  assign bus.err       = err_q;
endmodule
